// File: rtl/ex_stage_mdu.sv
// rtl/ex_stage_mdu.sv - RISC-V execute stage with forwarding, multiplier, iterative divider and EX/MEM register
module ex_stage_mdu #(
    parameter int XLEN          = 32,
    parameter int REG_ADDR_W    = 5,
    parameter int DIV_EARLY_OUT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            op,
    input  logic [XLEN-1:0]       operand_a,
    input  logic [XLEN-1:0]       operand_b,
    input  logic [1:0]            fwd_sel_a,
    input  logic [1:0]            fwd_sel_b,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  is_jump,
    input  logic [XLEN-1:0]       pt_wdata_in,
    input  logic [REG_ADDR_W-1:0] pt_rd_in,
    input  logic [XLEN-1:0]       pt_pc_in,
    input  logic                  mem_stall,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [XLEN-1:0]       res_out,
    output logic [XLEN-1:0]       pt_wdata_out,
    output logic [REG_ADDR_W-1:0] pt_rd_out,
    output logic [XLEN-1:0]       pt_pc_out,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_addr,
    output logic                  busy
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
    localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [XLEN-1:0]       op_a, op_b, alu_res;
    logic [2*XLEN-1:0]     a_ext, b_ext, prod;
    logic [SH_W-1:0]       shamt;
    logic                  is_div_op, is_single, fire;

    logic [XLEN-1:0]       quo, rem, dvs, dvd_raw;
    logic                  neg_q, neg_r, d_rem, d_zero, d_ovf;
    logic [XLEN-1:0]       d_wdata, d_pc;
    logic [REG_ADDR_W-1:0] d_rd;

    always_comb begin
        case (fwd_sel_a)
            2'd1:    op_a = res_out;
            2'd2:    op_a = wb_data;
            default: op_a = operand_a;
        endcase
        case (fwd_sel_b)
            2'd1:    op_b = res_out;
            2'd2:    op_b = wb_data;
            default: op_b = operand_b;
        endcase
    end

    assign is_div_op = (op >= OP_DIV) && (op <= OP_REMU);
    assign is_single = (op <= OP_MULHU);
    assign in_ready  = reset && (state == S_IDLE) && !mem_stall;
    assign fire      = in_valid && in_ready;
    assign shamt     = op_b[SH_W-1:0];

    // One shared multiplier: the operand extension picks signed/unsigned high-half variants.
    assign a_ext = {{XLEN{op_a[XLEN-1] && (op == OP_MULH || op == OP_MULHSU)}}, op_a};
    assign b_ext = {{XLEN{op_b[XLEN-1] && (op == OP_MULH)}}, op_b};
    assign prod  = a_ext * b_ext;

    always_comb begin
        case (op)
            OP_ADD:    alu_res = op_a + op_b;
            OP_SUB:    alu_res = op_a - op_b;
            OP_AND:    alu_res = op_a & op_b;
            OP_OR:     alu_res = op_a | op_b;
            OP_XOR:    alu_res = op_a ^ op_b;
            OP_SLL:    alu_res = op_a << shamt;
            OP_SRL:    alu_res = op_a >> shamt;
            OP_SRA:    alu_res = $signed(op_a) >>> shamt;
            OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_MUL:    alu_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_res = prod[2*XLEN-1:XLEN];
            default:   alu_res = '0;
        endcase
    end

    assign redirect_valid = fire && is_jump && is_single;
    assign redirect_addr  = redirect_valid ? {alu_res[XLEN-1:1], 1'b0} : '0;

    // Operand capture for the divider: magnitudes plus the sign of each result.
    logic            cap_signed, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    assign cap_signed = (op == OP_DIV) || (op == OP_REM);
    assign a_neg      = cap_signed && op_a[XLEN-1];
    assign b_neg      = cap_signed && op_b[XLEN-1];
    assign abs_a      = a_neg ? -op_a : op_a;
    assign abs_b      = b_neg ? -op_b : op_b;

    // Restoring step: the borrow out of the (XLEN+1)-bit subtract decides the quotient bit.
    logic [XLEN:0]   shifted, diff;
    logic            ge;
    logic [XLEN-1:0] rem_next, quo_next;
    assign shifted  = {rem, quo[XLEN-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign ge       = !diff[XLEN];
    assign rem_next = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], ge};

    logic [XLEN-1:0] q_fix, r_fix, div_res;
    always_comb begin
        q_fix = neg_q ? -quo : quo;
        r_fix = neg_r ? -rem : rem;
        if (d_zero) begin
            q_fix = '1;
            r_fix = dvd_raw;
        end else if (d_ovf) begin
            q_fix = dvd_raw;
            r_fix = '0;
        end
        div_res = d_rem ? r_fix : q_fix;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            res_out      <= '0;
            pt_wdata_out <= '0;
            pt_rd_out    <= '0;
            pt_pc_out    <= '0;
            quo          <= '0;
            rem          <= '0;
            dvs          <= '0;
            dvd_raw      <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            d_rem        <= 1'b0;
            d_zero       <= 1'b0;
            d_ovf        <= 1'b0;
            d_wdata      <= '0;
            d_rd         <= '0;
            d_pc         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire && is_div_op) begin
                        state   <= S_DIV;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        quo     <= abs_a;
                        rem     <= '0;
                        dvs     <= abs_b;
                        dvd_raw <= op_a;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        d_rem   <= (op == OP_REM) || (op == OP_REMU);
                        d_zero  <= (op_b == '0);
                        d_ovf   <= cap_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
                        d_wdata <= pt_wdata_in;
                        d_rd    <= pt_rd_in;
                        d_pc    <= pt_pc_in;
                    end
                end
                S_DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1) || ((DIV_EARLY_OUT != 0) && (d_zero || d_ovf)))
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (!mem_stall) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (!mem_stall) begin
                out_valid <= 1'b0;
                if (fire && !is_div_op) begin
                    res_out      <= alu_res;
                    pt_wdata_out <= pt_wdata_in;
                    pt_rd_out    <= pt_rd_in;
                    pt_pc_out    <= pt_pc_in;
                    out_valid    <= 1'b1;
                end else if (state == S_DONE) begin
                    res_out      <= div_res;
                    pt_wdata_out <= d_wdata;
                    pt_rd_out    <= d_rd;
                    pt_pc_out    <= d_pc;
                    out_valid    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb/tb_ex_stage_mdu.sv - directed vector bench for ex_stage_mdu
module tb_ex_stage_mdu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [4:0]  op;
    logic [31:0] operand_a, operand_b, wb_data;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        is_jump;
    logic [31:0] pt_wdata_in, pt_pc_in;
    logic [4:0]  pt_rd_in;
    logic        mem_stall, flush;
    logic        out_valid;
    logic [31:0] res_out, pt_wdata_out, pt_pc_out;
    logic [4:0]  pt_rd_out;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        busy;

    int total = 0;
    int bad   = 0;

    ex_stage_mdu #(.XLEN(32), .REG_ADDR_W(5), .DIV_EARLY_OUT(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .operand_a(operand_a), .operand_b(operand_b),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .wb_data(wb_data),
        .is_jump(is_jump), .pt_wdata_in(pt_wdata_in), .pt_rd_in(pt_rd_in),
        .pt_pc_in(pt_pc_in), .mem_stall(mem_stall), .flush(flush),
        .out_valid(out_valid), .res_out(res_out), .pt_wdata_out(pt_wdata_out),
        .pt_rd_out(pt_rd_out), .pt_pc_out(pt_pc_out),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_div(input string name, input logic [4:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_edges);
        int n;
        logic ready_seen;
        op = o; operand_a = a; operand_b = b; fwd_sel_a = 2'd0; fwd_sel_b = 2'd0;
        pt_rd_in = 5'd21; pt_pc_in = 32'h0000_2000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        ready_seen = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) ready_seen = 1'b1;
            step();
            n++;
        end
        check({name, "_res"}, res_out, exp);
        check({name, "_edges"}, n, exp_edges);
        check({name, "_ready_low"}, {31'd0, ready_seen}, 32'd0);
    endtask

    initial begin
        int k, first_valid;
        reset = 1'b0; in_valid = 1'b0; op = 5'd0; operand_a = '0; operand_b = '0;
        fwd_sel_a = 2'd0; fwd_sel_b = 2'd0; wb_data = 32'h0000_0100; is_jump = 1'b0;
        pt_wdata_in = '0; pt_rd_in = '0; pt_pc_in = '0; mem_stall = 1'b0; flush = 1'b0;

        vecs.push_back('{5'd0,  32'd5,          32'd7,          2'd0, 2'd0, 32'd12});
        vecs.push_back('{5'd1,  32'hDEAD_BEEF,  32'd2,          2'd1, 2'd0, 32'd10});
        vecs.push_back('{5'd13, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  2'd0, 2'd0, 32'hFFFF_FFFE});
        vecs.push_back('{5'd10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  2'd0, 2'd0, 32'h0000_0001});
        vecs.push_back('{5'd11, 32'hFFFF_FFFF,  32'd2,          2'd0, 2'd0, 32'hFFFF_FFFF});
        vecs.push_back('{5'd12, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  2'd0, 2'd0, 32'hFFFF_FFFF});
        vecs.push_back('{5'd7,  32'h8000_0000,  32'h0000_0024,  2'd0, 2'd0, 32'hF800_0000});
        vecs.push_back('{5'd6,  32'h8000_0000,  32'h0000_0024,  2'd0, 2'd0, 32'h0800_0000});
        vecs.push_back('{5'd5,  32'd1,          32'h0000_003F,  2'd0, 2'd0, 32'h8000_0000});
        vecs.push_back('{5'd8,  32'hFFFF_FFFF,  32'd1,          2'd0, 2'd0, 32'd1});
        vecs.push_back('{5'd9,  32'hFFFF_FFFF,  32'd1,          2'd0, 2'd0, 32'd0});
        vecs.push_back('{5'd4,  32'h0000_F0F0,  32'h0000_FF00,  2'd0, 2'd0, 32'h0000_0FF0});
        vecs.push_back('{5'd2,  32'h0000_F0F0,  32'h0000_FF00,  2'd0, 2'd0, 32'h0000_F000});
        vecs.push_back('{5'd3,  32'h0000_F0F0,  32'h0000_FF00,  2'd0, 2'd0, 32'h0000_FFF0});
        vecs.push_back('{5'd20, 32'd3,          32'd4,          2'd0, 2'd0, 32'd0});
        vecs.push_back('{5'd0,  32'd1,          32'd99,         2'd0, 2'd2, 32'h0000_0101});
        vecs.push_back('{5'd0,  32'd3,          32'd4,          2'd3, 2'd3, 32'd7});
        vecs.push_back('{5'd1,  32'd0,          32'd1,          2'd0, 2'd0, 32'hFFFF_FFFF});

        #2;
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_res_out", res_out, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        #1;
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i]) begin
            op = vecs[i].op; operand_a = vecs[i].a; operand_b = vecs[i].b;
            fwd_sel_a = vecs[i].fa; fwd_sel_b = vecs[i].fb;
            pt_rd_in = 5'(i); pt_pc_in = 32'h100 + 32'(i) * 4; pt_wdata_in = 32'hA000 + 32'(i);
            in_valid = 1'b1;
            step();
            check($sformatf("vec%0d_res", i), res_out, vecs[i].exp);
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_pc", i), pt_pc_out, 32'h100 + 32'(i) * 4);
        end
        fwd_sel_a = 2'd0; fwd_sel_b = 2'd0;
        in_valid = 1'b0;
        step();
        check("valid_clears", {31'd0, out_valid}, 32'd0);

        op = 5'd0; operand_a = 32'h0000_1001; operand_b = 32'd4; is_jump = 1'b1; in_valid = 1'b1;
        #1;
        check("redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("redirect_addr", redirect_addr, 32'h0000_1004);
        mem_stall = 1'b1;
        #1;
        check("redirect_stalled", {31'd0, redirect_valid}, 32'd0);
        check("redirect_addr_zero", redirect_addr, 32'd0);
        mem_stall = 1'b0;
        step();
        is_jump = 1'b0;
        check("jump_res", res_out, 32'h0000_1005);

        op = 5'd0; operand_a = 32'd40; operand_b = 32'd2; mem_stall = 1'b1;
        step();
        check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold_res", res_out, 32'h0000_1005);
        mem_stall = 1'b0;
        step();
        check("after_stall_res", res_out, 32'd42);
        in_valid = 1'b0;
        step();

        run_div("div_m7_2",   5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        check("div_pt_rd", {27'd0, pt_rd_out}, 32'd21);
        run_div("rem_m7_2",   5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_div("rem_7_m2",   5'd16, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
        run_div("divu_9_0",   5'd15, 32'd9,         32'd0,         32'hFFFF_FFFF, 2);
        run_div("remu_9_0",   5'd17, 32'd9,         32'd0,         32'd9,         2);
        run_div("div_m5_0",   5'd14, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 2);
        run_div("div_ovf",    5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_div("rem_ovf",    5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);

        op = 5'd15; operand_a = 32'd100; operand_b = 32'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        first_valid = -1;
        for (k = 1; k <= 45; k++) begin
            step();
            if (out_valid && first_valid < 0) first_valid = k;
            if (k == 35) check("stall_div_busy", {31'd0, busy}, 32'd1);
            if (k == 29) mem_stall = 1'b1;
            if (k == 40) mem_stall = 1'b0;
        end
        check("stall_div_edge", first_valid, 32'd41);
        check("stall_div_res", res_out, 32'd14);

        op = 5'd15; operand_a = 32'd1000; operand_b = 32'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (k = 1; k <= 9; k++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_ready", {31'd0, in_ready}, 32'd1);
        first_valid = 0;
        for (k = 0; k < 40; k++) begin
            if (out_valid) first_valid = 1;
            step();
        end
        check("flush_no_valid", first_valid, 32'd0);
        check("flush_res_kept", res_out, 32'd14);

        op = 5'd14; operand_a = 32'd100; operand_b = 32'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (k = 1; k <= 4; k++) step();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_valid", {31'd0, out_valid}, 32'd0);
        check("mid_reset_ready", {31'd0, in_ready}, 32'd0);
        check("mid_reset_res", res_out, 32'd0);
        step();
        reset = 1'b1;
        #1;
        check("release_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("release_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage_mdu.md
Name: ex_stage_mdu

Overview:
Parametrised execute stage for the 5-stage RISC-V core. It extends the single-cycle ALU stage with:
- operand forwarding muxes;
- a single-cycle multiplier;
- an iterative radix-2 divider with a valid/ready handshake toward decode;
- stall/flush control and jump redirect.

It sits between the ID/EX and EX/MEM boundaries and owns the EX/MEM pipeline register.

Parameters:
XLEN, 32, datapath width (operands, results, PC)
REG_ADDR_W, 5, register-file address width
DIV_EARLY_OUT, 1, 1 = divide-by-zero and signed-overflow cases finish after one iteration cycle

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
op  in  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; others → result 0
operand_a, operand_b  in  XLEN  operands from register read / immediate
fwd_sel_a, fwd_sel_b  in  2  0 = operand port, 1 = own EX/MEM result (res_out), 2 = wb_data, 3 = operand port
wb_data  in  XLEN  write-back forwarding value
is_jump  in  1  instruction redirects PC to the ALU result
pt_wdata_in  in  XLEN  store data, passed through
pt_rd_in  in  REG_ADDR_W  destination register, passed through
pt_pc_in  in  XLEN  instruction PC, passed through
mem_stall  in  1  downstream cannot take a result
flush  in  1  kill in-flight EX work
out_valid  out  1  EX/MEM register holds a valid instruction
res_out  out  XLEN  registered result
pt_wdata_out, pt_rd_out, pt_pc_out  out  as inputs  registered pass-through
redirect_valid  out  1  combinational PC redirect
redirect_addr  out  XLEN  combinational PC redirect target
busy  out  1  divider occupied

Behaviour:
- Reset (reset = 0, asynchronous):
  - FSM goes to IDLE.
  - out_valid, res_out, all pt_*_out, busy and the iteration counter all go to 0.
  - in_ready = 0 while reset is asserted.
- Forwarding: muxes are resolved combinationally before the ALU, multiplier and divider operand capture. fwd_sel = 1 always reads the current res_out.
- in_ready = (state == IDLE) && !mem_stall. A transfer occurs when in_valid && in_ready at a clock edge.
- Single-cycle ops (0–13):
  - On the transfer edge, res_out, the pass-throughs and out_valid = 1 are registered. Latency is 1.
  - Shifts use operand_b[log2(XLEN)-1:0].
  - MUL returns the low XLEN bits of the 2·XLEN product.
  - MULH/MULHSU/MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide ops (14–17), FSM IDLE → DIV → DONE → IDLE:
  - Transfer edge E0: latch |a| and |b| (signed ops) plus sign flags, op and pass-throughs. Set counter = 0, busy = 1, and clear out_valid.
  - DIV: one restoring shift-subtract step per edge. After XLEN steps (edges E1..E_XLEN), go to DONE.
  - DONE: apply result sign correction. When !mem_stall, register the result with out_valid = 1 (edge E_XLEN+1 if never stalled), clear busy, return to IDLE. If mem_stall, hold in DONE.
- Divide special cases (with DIV_EARLY_OUT = 1 they go to DONE at E1):
  - divisor 0: quotient = all ones, remainder = dividend.
  - signed overflow (most-negative / −1): quotient = dividend, remainder = 0.
- out_valid clears after one cycle unless a new result is registered. While mem_stall = 1, the EX/MEM register (out_valid, res_out, pass-throughs) holds its value.
- Flush:
  - Takes priority over everything except reset.
  - At the next edge: out_valid = 0, FSM → IDLE, busy = 0, counter = 0.
  - A transfer offered in the same cycle is discarded.
- Redirect:
  - redirect_valid = in_valid && in_ready && is_jump && op is single-cycle.
  - redirect_addr = the ALU result for that instruction, with bit 0 cleared.
  - Redirect outputs are 0 otherwise.
- Arithmetic wraps modulo 2^XLEN. SLT/SLTU return 0 or 1 zero-extended.

Test Plan:
1. Reset mid-divide (XLEN = 32): assert reset = 0 at E5 → busy = 0, out_valid = 0 immediately; in_ready = 1 once reset releases with no stall.
2. ADD 5 + 7, fwd 0; next cycle SUB with fwd_sel_a = 1, operand_b = 2 → res_out = 12, then 10, each on consecutive edges.
3. DIV −7 / 2 → quotient −3 (0xFFFFFFFD), out_valid at E33, in_ready = 0 during E1..E32. REM −7 / 2 → 0xFFFFFFFF.
4. DIVU 9 / 0 → 0xFFFFFFFF at E2. DIV 0x80000000 / −1 → 0x80000000, REM → 0.
5. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MUL → 0x00000001.
6. DIVU with mem_stall high from E30 to E40 → FSM waits in DONE, result registers at the edge after stall drops. flush at E10 of a second divide → out_valid never asserts, in_ready = 1 next cycle.
